serial_to_parallel: RTL

- Receive-side counterpart of the team's parallel-load / serial-shift-out register: accepts a serial bit stream, MSB first, one bit per enabled clock.
- Assembles WIDTH-bit words and presents each completed word on a held parallel output with a valid/acknowledge handshake.
- Sits at the far end of the serial link, feeding parallel consumers; flags overrun when the consumer falls behind.

---
 rtl/serial_pkg.sv | 9 +
 rtl/ser_bit_counter.sv | 46 ++++
 rtl/serial_to_parallel.sv | 97 +++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared constants for the serial link (shift-out and shift-in sides).
//   SER_WIDTH     : default word width in bits
//   SER_MSB_FIRST : bit order on the wire (1 = MSB first)
package serial_pkg;

  localparam int unsigned SER_WIDTH     = 4;
  localparam bit          SER_MSB_FIRST = 1'b1;

endpackage : serial_pkg

// File: rtl/ser_bit_counter.sv
// Bit position counter for a serial word, shared by the transmit and receive sides.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   en         : a bit is transferred on this edge
//   clr        : synchronous frame restart, wins over en
//   bit_cnt    : bits transferred in the current word, 0..WIDTH-1
//   last       : the current edge transfers the final bit of a word
module ser_bit_counter
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = SER_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             last
);

  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  assign last = en && !clr && (bit_cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (clr) begin
      bit_cnt_d = '0;
    end else if (en) begin
      // Wrap only through completion, so the count never reaches WIDTH.
      bit_cnt_d = last ? '0 : bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bit_cnt = bit_cnt_q;

endmodule : ser_bit_counter

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel receiver: assembles MSB-first serial bits into WIDTH-bit words and
// presents each completed word with a valid/acknowledge handshake.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   en, in     : serial bit strobe and data bit
//   clr        : synchronous frame restart (drops partial word, clears overrun)
//   out_ack    : consumer has taken out (only meaningful while out_valid)
//   out        : last completed word, held until the next completion
//   out_valid  : out holds an unacknowledged word
//   overrun    : sticky, a word completed over an unacknowledged one
//   bit_cnt    : bits received in the current partial word
module serial_to_parallel
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = SER_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in,
  input  logic             clr,
  input  logic             out_ack,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_cnt
);

  logic             last;
  // Only WIDTH-1 bits of history are ever needed: the final bit goes straight into out.
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  ser_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
    .bit_cnt (bit_cnt),
    .last    (last)
  );

  assign shifted = {shift_q, in};

  always_comb begin
    shift_d   = shift_q;
    out_d     = out_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (clr) begin
      shift_d = '0;
    end else if (en) begin
      shift_d = shifted[WIDTH-2:0];
    end

    // Handshake: a completion reloads and keeps valid; otherwise an ack drains it.
    if (last) begin
      out_d   = shifted;
      valid_d = 1'b1;
    end else if (valid_q && out_ack) begin
      valid_d = 1'b0;
    end

    if (clr) begin
      overrun_d = 1'b0;
    end else if (last && valid_q && !out_ack) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

endmodule : serial_to_parallel
